// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand and result bus for serial_adder
interface serial_adder_if #(parameter int WIDTH = 16);
    logic             start, sub, C_in, busy, done, C_out, overflow;
    logic [WIDTH-1:0] A, B, S;
    modport master (output start, sub, A, B, C_in, input busy, done, S, C_out, overflow);
    modport slave (input start, sub, A, B, C_in, output busy, done, S, C_out, overflow);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract processing SLICE bits per clock with carry, carry-out and signed overflow
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int KW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] op_a, op_b, part, part_nx;
    logic [KW-1:0]    k;
    logic [SLICE-1:0] sa, sb;
    logic [SLICE:0]   sum;
    logic             carry, last, c_msb;
    if (WIDTH < 2 || WIDTH % SLICE != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 2 and an integer multiple of SLICE");
    end
    assign sa       = op_a[k*SLICE +: SLICE];
    assign sb       = op_b[k*SLICE +: SLICE];
    assign sum      = {1'b0, sa} + {1'b0, sb} + {{SLICE{1'b0}}, carry};
    assign c_msb    = sa[SLICE-1] ^ sb[SLICE-1] ^ sum[SLICE-1];
    assign last     = k == KW'(N - 1);
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    // next state, and the partial result with the current slice merged in
    always_comb begin
        state_nx = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
        part_nx = part;
        part_nx[k*SLICE +: SLICE] = sum[SLICE-1:0];
    end
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    // operand latch, slice datapath, and result registers loaded entering DONE so they are valid with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a         <= '0;
            op_b         <= '0;
            part         <= '0;
            carry        <= 1'b0;
            k            <= '0;
            bus.S        <= '0;
            bus.C_out    <= 1'b0;
            bus.overflow <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            op_a  <= bus.A;
            op_b  <= bus.sub ? ~bus.B : bus.B;
            carry <= bus.sub | bus.C_in;
            k     <= '0;
        end else if (state == RUN) begin
            carry <= sum[SLICE];
            part  <= part_nx;
            k     <= k + 1'b1;
            if (last) begin
                bus.S        <= part_nx;
                bus.C_out    <= sum[SLICE];
                bus.overflow <= c_msb ^ sum[SLICE];
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder against an arithmetic reference model
module tb_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] prev_s;
    serial_adder_if #(.WIDTH(16)) bus ();
    serial_adder_if #(.WIDTH(16)) bus_w ();
    serial_adder #(.WIDTH(16), .SLICE(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    serial_adder #(.WIDTH(16), .SLICE(16)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));
    assign bus_w.start = bus.start;
    assign bus_w.sub   = bus.sub;
    assign bus_w.A     = bus.A;
    assign bus_w.B     = bus.B;
    assign bus_w.C_in  = bus.C_in;
    always #5 clk = ~clk;

    // returns {overflow, C_out, S} from plain integer arithmetic
    function automatic logic [17:0] model(input bit s, input logic [15:0] a, input logic [15:0] b, input bit cin);
        int full, r;
        full = s ? int'(a) - int'(b) + 65536 : int'(a) + int'(b) + int'(cin);
        r = s ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b)) + int'(cin);
        return {r > 32767 || r < -32768, full[16], full[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit s, input logic [15:0] a, input logic [15:0] b, input bit cin, input bit disturb);
        logic [17:0] m;
        int n, nw, nb;
        m = model(s, a, b, cin);
        bus.start = 1'b1;
        bus.sub   = s;
        bus.A     = a;
        bus.B     = b;
        bus.C_in  = cin;
        tick;
        n = 1;
        nw = 0;
        nb = 0;
        while (n < 20) begin
            if (bus_w.done) begin
                nw = n;
                check("wide_s", bus_w.S, m[15:0]);
                check("wide_cout", bus_w.C_out, m[16]);
                check("wide_ovf", bus_w.overflow, m[17]);
            end
            if (bus.busy) nb++;
            if (bus.done) break;
            check("hold_s", bus.S, prev_s);
            bus.start = disturb && n == 2;
            bus.A     = (disturb && n == 2) ? 16'hAAAA : 16'($urandom);
            bus.B     = 16'($urandom);
            bus.sub   = 1'($urandom);
            bus.C_in  = 1'($urandom);
            tick;
            n++;
        end
        bus.start = 1'b0;
        check("latency", n, 5);
        check("wide_latency", nw, 2);
        check("busy_cycles", nb, 5);
        check("s", bus.S, m[15:0]);
        check("cout", bus.C_out, m[16]);
        check("ovf", bus.overflow, m[17]);
        tick;
        check("done_pulse", bus.done, 1'b0);
        check("idle_busy", bus.busy, 1'b0);
        check("s_after", bus.S, m[15:0]);
        prev_s = m[15:0];
    endtask

    initial begin
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.C_in  = 1'b0;
        tick;
        tick;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_s", bus.S, 16'h0);
        check("rst_cout", bus.C_out, 1'b0);
        check("rst_ovf", bus.overflow, 1'b0);
        check("rst_wide_s", bus_w.S, 16'h0);
        rst_n = 1'b1;
        prev_s = 16'h0;
        tick;
        run_op(1'b0, 16'h1234, 16'h0FED, 1'b0, 1'b0);
        run_op(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b1);
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(1'b0, 16'h00FF, 16'h0000, 1'b1, 1'b0);
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b0);
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0);
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.A     = 16'h4321;
        bus.B     = 16'h1111;
        tick;
        bus.start = 1'b0;
        tick;
        check("mid_run_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_done", bus.done, 1'b0);
        check("arst_s", bus.S, 16'h0);
        check("arst_cout", bus.C_out, 1'b0);
        check("arst_ovf", bus.overflow, 1'b0);
        tick;
        check("arst_idle", bus.busy, 1'b0);
        rst_n = 1'b1;
        prev_s = 16'h0;
        tick;
        run_op(1'b0, 16'h1234, 16'h0FED, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++)
            run_op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
